// File: rtl/gpio_conv_sequencer.sv
// Toggle-handshaked GPIO command sequencer for the convolution datapath: bank writes, runs, result reads.
// Optional run watchdog: define CONV_SEQ_WATCHDOG_EN.
module gpio_conv_sequencer #(
  parameter int N_BANKS     = 3,
  parameter int RAM_WIDTH   = 13,
  parameter int NB_ADDRESS  = 10,
  parameter int NB_IMAGE    = 10,
  parameter int GPIO_D      = 32,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  CLK100MHZ,
  input  logic                  i_reset,
  input  logic [GPIO_D-1:0]     i_gpio_cmd,
  output logic [GPIO_D-1:0]     o_gpio_status,
  output logic [N_BANKS-1:0]    o_bank_wen,
  output logic [NB_ADDRESS-1:0] o_bank_addr,
  output logic [RAM_WIDTH-1:0]  o_bank_data,
  output logic [NB_ADDRESS-1:0] o_res_addr,
  input  logic [RAM_WIDTH-1:0]  i_res_data,
  output logic [NB_IMAGE-1:0]   o_img_length,
  output logic                  o_start,
  output logic                  o_valid,
  input  logic                  i_eop
);

  // state   | meaning
  // IDLE    | waiting for a pending command, decodes it
  // RUN     | convolution running, waiting for i_eop
  // RD_WAIT | counting down result-bank read latency
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RD_WAIT = 2'd2} state_t;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_SET_LEN  = 3'd1;
  localparam logic [2:0] OP_WR_BANK  = 3'd2;
  localparam logic [2:0] OP_RST_PTR  = 3'd3;
  localparam logic [2:0] OP_START    = 3'd4;
  localparam logic [2:0] OP_READ_RES = 3'd5;
  localparam logic [2:0] OP_SOFT_RST = 3'd6;

  localparam logic [4:0]          N_BANKS_L   = 5'(N_BANKS);
  localparam logic [1:0]          RD_LOAD     = 2'(RD_LAT - 1);
  localparam logic [NB_IMAGE-1:0] IMG_LEN_RST = NB_IMAGE'(10);

  state_t                  state;
  logic [GPIO_D-1:0]       cmd_q;
  logic                    ack;
  logic                    busy;
  logic                    done;
  logic                    error;
  logic [RAM_WIDTH-1:0]    rd_data;
  logic [NB_ADDRESS-1:0]   wr_ptr [N_BANKS];
  logic [NB_ADDRESS-1:0]   res_ptr;
  logic [1:0]              rd_cnt;

  logic                    pending;
  logic [2:0]              op;
  logic [3:0]              bank;
  logic [RAM_WIDTH-1:0]    data;
  logic                    bank_ok;

  assign pending = cmd_q[31] != ack;
  assign op      = cmd_q[30:28];
  assign bank    = cmd_q[27:24];
  assign data    = cmd_q[RAM_WIDTH-1:0];
  assign bank_ok = {1'b0, bank} < N_BANKS_L;

  generate
    if (RAM_WIDTH < 24) begin : g_unused_cmd
      logic unused_cmd;
      assign unused_cmd = ^cmd_q[23:RAM_WIDTH];
    end
  endgenerate

`ifdef CONV_SEQ_WATCHDOG_EN
  localparam int            WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    o_gpio_status                  = '0;
    o_gpio_status[31]              = ack;
    o_gpio_status[30]              = busy;
    o_gpio_status[29]              = done;
    o_gpio_status[28]              = error;
    o_gpio_status[RAM_WIDTH-1:0]   = rd_data;
  end

  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) cmd_q <= '0;
    else         cmd_q <= i_gpio_cmd;
  end

  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      ack          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      rd_data      <= '0;
      res_ptr      <= '0;
      rd_cnt       <= '0;
      o_bank_wen   <= '0;
      o_bank_addr  <= '0;
      o_bank_data  <= '0;
      o_res_addr   <= '0;
      o_img_length <= IMG_LEN_RST;
      o_start      <= 1'b0;
      o_valid      <= 1'b0;
      for (int b = 0; b < N_BANKS; b++) wr_ptr[b] <= '0;
`ifdef CONV_SEQ_WATCHDOG_EN
      wd_cnt       <= '0;
`endif
    end else if (pending && op == OP_SOFT_RST) begin
      // Soft reset wins in every state and keeps the programmed image length.
      state        <= IDLE;
      ack          <= ~ack;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      rd_data      <= '0;
      res_ptr      <= '0;
      rd_cnt       <= '0;
      o_bank_wen   <= '0;
      o_bank_addr  <= '0;
      o_bank_data  <= '0;
      o_res_addr   <= '0;
      o_start      <= 1'b0;
      o_valid      <= 1'b0;
      for (int b = 0; b < N_BANKS; b++) wr_ptr[b] <= '0;
`ifdef CONV_SEQ_WATCHDOG_EN
      wd_cnt       <= '0;
`endif
    end else begin
      o_bank_wen <= '0;
      o_start    <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            case (op)
              OP_NOP: ack <= ~ack;
              OP_SET_LEN: begin
                o_img_length <= cmd_q[NB_IMAGE-1:0];
                ack          <= ~ack;
              end
              OP_WR_BANK: begin
                ack <= ~ack;
                if (bank_ok) begin
                  o_bank_data <= data;
                  for (int b = 0; b < N_BANKS; b++) begin
                    if (bank == 4'(b)) begin
                      o_bank_wen[b] <= 1'b1;
                      o_bank_addr   <= wr_ptr[b];
                      wr_ptr[b]     <= wr_ptr[b] + 1'b1;
                      if (wr_ptr[b] == '1) error <= 1'b1;
                    end
                  end
                end else begin
                  error <= 1'b1;
                end
              end
              OP_RST_PTR: begin
                for (int b = 0; b < N_BANKS; b++) wr_ptr[b] <= '0;
                res_ptr <= '0;
                error   <= 1'b0;
                done    <= 1'b0;
                ack     <= ~ack;
              end
              OP_START: begin
                o_start <= 1'b1;
                o_valid <= 1'b1;
                busy    <= 1'b1;
                done    <= 1'b0;
                ack     <= ~ack;
                state   <= RUN;
`ifdef CONV_SEQ_WATCHDOG_EN
                wd_cnt  <= WD_LOAD;
`endif
              end
              OP_READ_RES: begin
                o_res_addr <= res_ptr;
                rd_cnt     <= RD_LOAD;
                state      <= RD_WAIT;
              end
              default: begin
                error <= 1'b1;
                ack   <= ~ack;
              end
            endcase
          end
        end
        RUN: begin
          if (i_eop) begin
            o_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
`ifdef CONV_SEQ_WATCHDOG_EN
          end else if (wd_cnt == '0) begin
            o_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b1;
            state   <= IDLE;
          end else begin
            wd_cnt  <= wd_cnt - 1'b1;
`endif
          end
        end
        RD_WAIT: begin
          if (rd_cnt == '0) begin
            rd_data <= i_res_data;
            ack     <= ~ack;
            res_ptr <= res_ptr + 1'b1;
            state   <= IDLE;
          end else begin
            rd_cnt  <= rd_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_conv_sequencer.sv
// Scoreboard bench for gpio_conv_sequencer: expected acks/writes queued at issue, popped by a monitor.
module tb_gpio_conv_sequencer;
  localparam int N_BANKS    = 3;
  localparam int RAM_WIDTH  = 13;
  localparam int NB_ADDRESS = 10;
  localparam int NB_IMAGE   = 10;
  localparam int GPIO_D     = 32;
  localparam int RD_LAT     = 2;
`ifdef CONV_SEQ_WATCHDOG_EN
  localparam int TIMEOUT_CYC = 100;
`else
  localparam int TIMEOUT_CYC = 65535;
`endif

  localparam logic [2:0] OP_NOP = 3'd0, OP_SET_LEN = 3'd1, OP_WR = 3'd2, OP_RST_PTR = 3'd3;
  localparam logic [2:0] OP_START = 3'd4, OP_READ = 3'd5, OP_SOFT = 3'd6, OP_RSVD = 3'd7;

  logic                  CLK100MHZ;
  logic                  i_reset;
  logic [GPIO_D-1:0]     i_gpio_cmd;
  logic [GPIO_D-1:0]     o_gpio_status;
  logic [N_BANKS-1:0]    o_bank_wen;
  logic [NB_ADDRESS-1:0] o_bank_addr;
  logic [RAM_WIDTH-1:0]  o_bank_data;
  logic [NB_ADDRESS-1:0] o_res_addr;
  logic [RAM_WIDTH-1:0]  i_res_data;
  logic [NB_IMAGE-1:0]   o_img_length;
  logic                  o_start;
  logic                  o_valid;
  logic                  i_eop;

  gpio_conv_sequencer #(
    .N_BANKS(N_BANKS), .RAM_WIDTH(RAM_WIDTH), .NB_ADDRESS(NB_ADDRESS), .NB_IMAGE(NB_IMAGE),
    .GPIO_D(GPIO_D), .RD_LAT(RD_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .i_reset(i_reset), .i_gpio_cmd(i_gpio_cmd), .o_gpio_status(o_gpio_status),
    .o_bank_wen(o_bank_wen), .o_bank_addr(o_bank_addr), .o_bank_data(o_bank_data),
    .o_res_addr(o_res_addr), .i_res_data(i_res_data), .o_img_length(o_img_length),
    .o_start(o_start), .o_valid(o_valid), .i_eop(i_eop)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  int edge_cnt = 0;
  always @(posedge CLK100MHZ) edge_cnt++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          op;
    int          exp_edge;
    logic [31:0] status;
    logic [9:0]  res_addr;
  } ack_rec_t;

  typedef struct {
    logic [2:0]  wen;
    logic [9:0]  addr;
    logic [12:0] data;
  } wr_rec_t;

  ack_rec_t ack_q[$];
  wr_rec_t  wr_q[$];

  // Reference model of host-visible state
  logic        req, m_ack, m_busy, m_done, m_err;
  logic [12:0] m_rdata;
  logic [9:0]  m_res_addr, m_res_ptr;
  logic [9:0]  m_ptr [3];

  function automatic logic [31:0] mk_status();
    return {m_ack, m_busy, m_done, m_err, 15'd0, m_rdata};
  endfunction

  task automatic model_clear();
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_rdata = '0;
    m_res_addr = '0; m_res_ptr = '0;
    for (int b = 0; b < 3; b++) m_ptr[b] = '0;
  endtask

  ack_rec_t mon_a;
  wr_rec_t  mon_w;
  logic     last_ack = 1'b0;

  always @(negedge CLK100MHZ) begin
    if (i_reset) begin
      last_ack = 1'b0;
    end else begin
      if (o_bank_wen != '0) begin
        if (wr_q.size() == 0) check("unexpected_wen", 32'(o_bank_wen), 32'd0);
        else begin
          mon_w = wr_q.pop_front();
          check("wr_wen", 32'(o_bank_wen), 32'(mon_w.wen));
          check("wr_addr", 32'(o_bank_addr), 32'(mon_w.addr));
          check("wr_data", 32'(o_bank_data), 32'(mon_w.data));
        end
      end
      if (o_gpio_status[31] != last_ack) begin
        last_ack = o_gpio_status[31];
        if (ack_q.size() == 0) check("unexpected_ack", 32'(ack_q.size()), 32'd1);
        else begin
          mon_a = ack_q.pop_front();
          check($sformatf("ack_lat_op%0d", mon_a.op), 32'(edge_cnt), 32'(mon_a.exp_edge));
          check($sformatf("ack_status_op%0d", mon_a.op), o_gpio_status, mon_a.status);
          check($sformatf("res_addr_op%0d", mon_a.op), 32'(o_res_addr), 32'(mon_a.res_addr));
        end
      end
    end
  end

  // Caller updates the model to post-command values before calling.
  task automatic issue(input logic [2:0] op, input logic [3:0] bank, input logic [12:0] data, input int lat);
    ack_rec_t r;
    req   = ~req;
    m_ack = ~m_ack;
    r.op       = int'(op);
    r.exp_edge = edge_cnt + 2 + lat;
    r.status   = mk_status();
    r.res_addr = m_res_addr;
    ack_q.push_back(r);
    i_gpio_cmd = {req, op, bank, 11'd0, data};
  endtask

  task automatic wait_ack(input int budget);
    int n = 0;
    while (ack_q.size() != 0 && n < budget) begin
      @(negedge CLK100MHZ);
      n++;
    end
    if (ack_q.size() != 0) begin
      check("ack_timeout", 32'(ack_q.size()), 32'd0);
      ack_q.delete();
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [12:0] data);
    issue(op, 4'd0, data, 0);
    wait_ack(10);
  endtask

  task automatic do_write(input int b, input logic [12:0] data);
    wr_rec_t w;
    if (b < N_BANKS) begin
      w.wen  = 3'(1 << b);
      w.addr = m_ptr[b];
      w.data = data;
      wr_q.push_back(w);
      if (m_ptr[b] == 10'h3FF) m_err = 1'b1;
      m_ptr[b] = m_ptr[b] + 1'b1;
    end else begin
      m_err = 1'b1;
    end
    issue(OP_WR, 4'(b), data, 0);
    wait_ack(10);
  endtask

  task automatic do_read(input logic [12:0] rdata);
    i_res_data = rdata;
    m_rdata    = rdata;
    m_res_addr = m_res_ptr;
    m_res_ptr  = m_res_ptr + 1'b1;
    issue(OP_READ, 4'd0, 13'd0, RD_LAT);
    wait_ack(20);
  endtask

  initial begin
    ack_rec_t r;
    logic     prev_ack;
    int       s_edge;

    i_reset = 1'b1; i_gpio_cmd = '0; i_res_data = '0; i_eop = 1'b0;
    req = 1'b0; m_ack = 1'b0;
    model_clear();
    repeat (3) @(negedge CLK100MHZ);
    i_reset = 1'b0;
    @(negedge CLK100MHZ);

    check("rst_status", o_gpio_status, 32'd0);
    check("rst_wen", 32'(o_bank_wen), 32'd0);
    check("rst_bank_addr", 32'(o_bank_addr), 32'd0);
    check("rst_bank_data", 32'(o_bank_data), 32'd0);
    check("rst_res_addr", 32'(o_res_addr), 32'd0);
    check("rst_img_len", 32'(o_img_length), 32'd10);
    check("rst_start", 32'(o_start), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);

    do_cmd(OP_NOP, 13'h1FFF);
    do_write(1, 13'h005);
    do_write(1, 13'h006);
    do_write(1, 13'h007);
    do_write(0, 13'h0AA);

    do_cmd(OP_SET_LEN, 13'd36);
    check("img_len_set", 32'(o_img_length), 32'd36);

    m_busy = 1'b1; m_done = 1'b0;
    issue(OP_START, 4'd0, 13'd0, 0);
    @(negedge CLK100MHZ);
    check("start_early", 32'(o_start), 32'd0);
    @(negedge CLK100MHZ);
    check("start_pulse", 32'(o_start), 32'd1);
    check("valid_on", 32'(o_valid), 32'd1);
    @(negedge CLK100MHZ);
    check("start_single", 32'(o_start), 32'd0);

    prev_ack = m_ack;
    i_res_data = 13'h0555;
    m_busy = 1'b0; m_done = 1'b1;
    m_rdata = 13'h0555; m_res_addr = m_res_ptr; m_res_ptr = m_res_ptr + 1'b1;
    issue(OP_READ, 4'd0, 13'd0, 1000);
    repeat (50) @(negedge CLK100MHZ);
    check("run_valid_hold", 32'(o_valid), 32'd1);
    check("run_busy", 32'(o_gpio_status[30]), 32'd1);
    check("run_read_held", 32'(o_gpio_status[31]), 32'(prev_ack));

    i_eop = 1'b1;
    r = ack_q.pop_front();
    r.exp_edge = edge_cnt + 2 + RD_LAT;
    ack_q.push_front(r);
    @(negedge CLK100MHZ);
    i_eop = 1'b0;
    check("eop_valid_off", 32'(o_valid), 32'd0);
    check("eop_busy", 32'(o_gpio_status[30]), 32'd0);
    check("eop_done", 32'(o_gpio_status[29]), 32'd1);
    wait_ack(20);

    model_clear();
    do_cmd(OP_SOFT, 13'd0);
    check("soft_img_len", 32'(o_img_length), 32'd36);
    check("soft_valid", 32'(o_valid), 32'd0);

    do_read(13'h1ABC);
    do_read(13'h0123);

    do_write(5, 13'h00F);
    m_err = 1'b1;
    do_cmd(OP_RSVD, 13'd0);
    m_err = 1'b0;
    for (int b = 0; b < 3; b++) m_ptr[b] = '0;
    do_cmd(OP_RST_PTR, 13'd0);
    check("err_cleared", 32'(o_gpio_status[28]), 32'd0);

    for (int i = 0; i < 1024; i++) do_write(2, 13'(i));
    check("wrap_err", 32'(o_gpio_status[28]), 32'd1);
    do_write(2, 13'h011);
    m_err = 1'b0;
    for (int b = 0; b < 3; b++) m_ptr[b] = '0;
    do_cmd(OP_RST_PTR, 13'd0);
    do_write(1, 13'h022);

`ifdef CONV_SEQ_WATCHDOG_EN
    m_busy = 1'b1; m_done = 1'b0;
    issue(OP_START, 4'd0, 13'd0, 0);
    s_edge = edge_cnt + 2;
    wait_ack(10);
    while (edge_cnt < s_edge + TIMEOUT_CYC - 1) @(negedge CLK100MHZ);
    check("wd_valid_hold", 32'(o_valid), 32'd1);
    @(negedge CLK100MHZ);
    check("wd_valid_off", 32'(o_valid), 32'd0);
    check("wd_busy", 32'(o_gpio_status[30]), 32'd0);
    check("wd_done", 32'(o_gpio_status[29]), 32'd0);
    check("wd_err", 32'(o_gpio_status[28]), 32'd1);
    m_busy = 1'b0; m_err = 1'b0;
    for (int b = 0; b < 3; b++) m_ptr[b] = '0;
    do_cmd(OP_RST_PTR, 13'd0);
`else
    s_edge = 0;
`endif

    m_busy = 1'b1; m_done = 1'b0;
    issue(OP_START, 4'd0, 13'd0, 0);
    wait_ack(10);
    repeat (5) @(negedge CLK100MHZ);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    #2 i_reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(o_valid), 32'd0);
    check("async_rst_status", o_gpio_status, 32'd0);
    check("async_rst_wen", 32'(o_bank_wen), 32'd0);
    check("async_rst_img_len", 32'(o_img_length), 32'd10);
    i_gpio_cmd = '0; req = 1'b0; m_ack = 1'b0;
    model_clear();
    ack_q.delete(); wr_q.delete();
    @(negedge CLK100MHZ);
    i_reset = 1'b0;
    @(negedge CLK100MHZ);
    check("post_rst_img_len", 32'(o_img_length), 32'd10);
    check("post_rst_valid", 32'(o_valid), 32'd0);
    check("post_rst_res_addr", 32'(o_res_addr), 32'd0);
    do_write(0, 13'h033);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got edge %0d expected finish", edge_cnt);
    $fatal(1, "timeout");
  end

endmodule
